// File: rtl/spi_frame_master.sv
// rtl/spi_frame_master.sv - SPI mode-0 frame master, MSB first, with leading-bit MISO capture
module spi_frame_master #(
  parameter int CLK_DIV    = 2,
  parameter int FRAME_BITS = 32,
  parameter int READ_BITS  = 16,
  parameter int CS_SETUP   = 4,
  parameter int CS_HOLD    = 4,
  parameter int CS_IDLE    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FRAME_BITS-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [READ_BITS-1:0]  rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  SCK,
  output logic                  MOSI,
  input  logic                  MISO,
  output logic                  SSEL
);

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  localparam int CW = $clog2(max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_IDLE) + 1);
  localparam int BW = $clog2(FRAME_BITS + 1);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("spi_frame_master: CLK_DIV must be >= 2");
  end
  if (CS_IDLE < 4) begin : g_bad_cs_idle
    $error("spi_frame_master: CS_IDLE must be >= 4");
  end
  if (READ_BITS > FRAME_BITS) begin : g_bad_read_bits
    $error("spi_frame_master: READ_BITS must not exceed FRAME_BITS");
  end

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         bit_cnt;
  logic [FRAME_BITS-1:0] tx_shift;
  logic [READ_BITS-1:0]  rx_shift;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
      SCK      <= 1'b0;
      MOSI     <= 1'b0;
      SSEL     <= 1'b1;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            SSEL     <= 1'b0;
            MOSI     <= tx_data[FRAME_BITS-1];
            tx_shift <= tx_data;
            bit_cnt  <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            tx_ready <= 1'b0;
            state    <= SETUP;
          end else begin
            tx_ready <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt == CW'(CS_SETUP - 1)) begin
            cnt   <= '0;
            state <= LOW;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOW: begin
          if (cnt == CW'(CLK_DIV - 1)) begin
            cnt   <= '0;
            SCK   <= 1'b1;
            state <= HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (cnt == CW'(CLK_DIV - 1)) begin
            cnt     <= '0;
            SCK     <= 1'b0;
            bit_cnt <= bit_cnt + 1'b1;
            // Late sample: the slave only shifts after it has synchronised the previous fall.
            if (bit_cnt < BW'(READ_BITS))
              rx_shift <= (rx_shift << 1) | READ_BITS'(MISO);
            if (bit_cnt == BW'(FRAME_BITS - 1)) begin
              MOSI  <= 1'b0;
              state <= HOLD;
            end else begin
              tx_shift <= tx_shift << 1;
              MOSI     <= tx_shift[FRAME_BITS-2];
              state    <= LOW;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (cnt == CW'(CS_HOLD - 1)) begin
            cnt      <= '0;
            SSEL     <= 1'b1;
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
            state    <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == CW'(CS_IDLE - 1)) begin
            cnt      <= '0;
            busy     <= 1'b0;
            tx_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_master.sv
// tb/tb_spi_frame_master.sv - directed bench: two masters (CLK_DIV 2 and 5) driving slave models
module tb_spi_frame_master;

  localparam logic [15:0] READ_OUT = 16'hBEEF;

  logic        clk;
  logic        rst_n;
  logic        mon_clr;
  logic [31:0] tx_data   [2];
  logic        tx_valid  [2];
  logic        tx_ready  [2];
  logic [15:0] rx_data   [2];
  logic        rx_valid  [2];
  logic        busy      [2];
  logic        sck       [2];
  logic        mosi      [2];
  logic        miso      [2];
  logic        ssel      [2];
  logic [1:0]  miso_mode [2];

  int          n_low  [2];
  int          n_sckh [2];
  int          n_rise [2];
  int          n_rxv  [2];
  int          n_rdy  [2];
  int          n_busy [2];
  int          n_fr   [2];
  int          gap    [2];
  logic [31:0] cap    [2];
  logic [31:0] s_prev [2];
  logic [31:0] s_last [2];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int DIV = (g == 0) ? 2 : 5;

    spi_frame_master #(.CLK_DIV(DIV)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tx_data  (tx_data[g]),
      .tx_valid (tx_valid[g]),
      .tx_ready (tx_ready[g]),
      .rx_data  (rx_data[g]),
      .rx_valid (rx_valid[g]),
      .busy     (busy[g]),
      .SCK      (sck[g]),
      .MOSI     (mosi[g]),
      .MISO     (miso[g]),
      .SSEL     (ssel[g])
    );

    // Slave model: 2-flop synchronisers, samples MOSI on synced rise, shifts MISO on synced fall.
    logic        sck_q1, sck_q2, sck_q3, ssel_q1, ssel_q2, mosi_q1, mosi_q2;
    logic [31:0] s_sh, s_word;
    logic [5:0]  s_cnt;
    logic [15:0] s_miso;
    logic        s_ready;

    always @(posedge clk) begin
      sck_q1  <= sck[g];   sck_q2  <= sck_q1;  sck_q3 <= sck_q2;
      ssel_q1 <= ssel[g];  ssel_q2 <= ssel_q1;
      mosi_q1 <= mosi[g];  mosi_q2 <= mosi_q1;
      s_ready <= 1'b0;
      if (ssel_q2) begin
        s_cnt  <= '0;
        s_miso <= READ_OUT;
      end else begin
        if (sck_q2 && !sck_q3) begin
          s_sh  <= {s_sh[30:0], mosi_q2};
          s_cnt <= s_cnt + 6'd1;
          if (s_cnt == 6'd31) begin
            s_word  <= {s_sh[30:0], mosi_q2};
            s_ready <= 1'b1;
          end
        end
        if (!sck_q2 && sck_q3) s_miso <= s_miso << 1;
      end
    end

    assign miso[g] = (miso_mode[g] == 2'd1) ? 1'b1 :
                     (miso_mode[g] == 2'd2) ? 1'b0 : s_miso[15];

    int          m_low, m_sckh, m_rise, m_rxv, m_rdy, m_busy, m_fr, m_gap, hi_run;
    logic [31:0] m_cap, m_prev, m_last;
    logic        sck_p, ssel_p;

    always @(negedge clk) begin
      if (mon_clr) begin
        m_low <= 0; m_sckh <= 0; m_rise <= 0; m_rxv <= 0; m_rdy <= 0;
        m_busy <= 0; m_fr <= 0; m_gap <= 0; hi_run <= 0;
        m_cap <= '0; m_prev <= '0; m_last <= '0;
        sck_p <= sck[g]; ssel_p <= ssel[g];
      end else begin
        sck_p  <= sck[g];
        ssel_p <= ssel[g];
        if (!ssel[g]) m_low <= m_low + 1;
        if (sck[g])   m_sckh <= m_sckh + 1;
        if (busy[g])  m_busy <= m_busy + 1;
        if (rx_valid[g]) m_rxv <= m_rxv + 1;
        if (sck[g] && !sck_p) begin
          m_cap  <= {m_cap[30:0], mosi[g]};
          m_rise <= m_rise + 1;
        end
        if (!ssel[g] && ssel_p) m_fr <= m_fr + 1;
        if (ssel[g]) hi_run <= hi_run + 1;
        else begin
          if (hi_run > 0) m_gap <= hi_run;
          hi_run <= 0;
        end
        if (s_ready) begin
          m_prev <= m_last;
          m_last <= s_word;
          m_rdy  <= m_rdy + 1;
        end
      end
    end

    assign n_low[g] = m_low;   assign n_sckh[g] = m_sckh; assign n_rise[g] = m_rise;
    assign n_rxv[g] = m_rxv;   assign n_rdy[g]  = m_rdy;  assign n_busy[g] = m_busy;
    assign n_fr[g]  = m_fr;    assign gap[g]    = m_gap;  assign cap[g]    = m_cap;
    assign s_prev[g] = m_prev; assign s_last[g] = m_last;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk); mon_clr = 1'b1;
    @(posedge clk); mon_clr = 1'b0;
  endtask

  task automatic send(input int i, input logic [31:0] w);
    int n = 0;
    @(negedge clk);
    while (!tx_ready[i] && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) check("ready_timeout", 32'd0, 32'd1);
    tx_data[i]  = w;
    tx_valid[i] = 1'b1;
    @(negedge clk);
    tx_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (busy[i] && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) check("idle_timeout", 32'd0, 32'd1);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    time t1, t2;
    int  n;
    logic bad;
    rst_n   = 1'b0;
    mon_clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tx_data[i] = '0; tx_valid[i] = 1'b0; miso_mode[i] = 2'd0;
    end

    repeat (3) @(negedge clk);
    check("rst_ssel",     32'(ssel[0]),     32'd1);
    check("rst_sck",      32'(sck[0]),      32'd0);
    check("rst_mosi",     32'(mosi[0]),     32'd0);
    check("rst_tx_ready", 32'(tx_ready[0]), 32'd0);
    check("rst_busy",     32'(busy[0]),     32'd0);
    check("rst_rx_valid", 32'(rx_valid[0]), 32'd0);
    check("rst_rx_data",  32'(rx_data[0]),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(tx_ready[0]), 32'd1);

    // Frame timing and MOSI bit order
    clear_mon();
    send(0, 32'h8A5C_1234);
    wait_idle(0);
    check("t1_mosi",      cap[0],          32'h8A5C_1234);
    check("t1_rises",     32'(n_rise[0]),  32'd32);
    check("t1_ssel_low",  32'(n_low[0]),   32'd136);
    check("t1_sck_high",  32'(n_sckh[0]),  32'd64);
    check("t1_busy",      32'(n_busy[0]),  32'd144);

    // Loopback through the slave model
    clear_mon();
    send(0, 32'h8040_0ABC);
    wait_idle(0);
    check("t2_slave_word", s_last[0],       32'h8040_0ABC);
    check("t2_slave_rdy",  32'(n_rdy[0]),   32'd1);
    check("t2_rx_data",    32'(rx_data[0]), 32'h0000_BEEF);
    check("t2_rx_valid",   32'(n_rxv[0]),   32'd1);

    // Back-to-back with tx_valid held high
    clear_mon();
    @(negedge clk);
    n = 0;
    while (!tx_ready[0] && n < 2000) begin @(negedge clk); n++; end
    tx_data[0] = 32'hA5A5_0F0F; tx_valid[0] = 1'b1;
    @(negedge clk); t1 = $time;
    tx_data[0] = 32'h3C3C_F00D;
    n = 0;
    while (!tx_ready[0] && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) check("t3_ready_timeout", 32'd0, 32'd1);
    @(negedge clk); t2 = $time;
    tx_valid[0] = 1'b0;
    wait_idle(0);
    check("t3_accept_period", 32'((t2 - t1) / 10), 32'd145);
    // GAP cycles plus the single IDLE cycle in which the next frame is accepted
    check("t3_ssel_gap",  32'(gap[0]),   32'd9);
    check("t3_word_a",    s_prev[0],     32'hA5A5_0F0F);
    check("t3_word_b",    s_last[0],     32'h3C3C_F00D);
    check("t3_frames",    32'(n_fr[0]),  32'd2);

    // Inputs churned mid-frame are ignored
    clear_mon();
    send(0, 32'h1357_9BDF);
    bad = 1'b0;
    for (int k = 0; k < 120; k++) begin
      tx_valid[0] = ~tx_valid[0];
      tx_data[0]  = $urandom;
      @(negedge clk);
      if (tx_ready[0]) bad = 1'b1;
    end
    tx_valid[0] = 1'b0;
    wait_idle(0);
    check("t4_ready_low", 32'(bad),      32'd0);
    check("t4_mosi",      cap[0],        32'h1357_9BDF);
    check("t4_frames",    32'(n_fr[0]),  32'd1);
    check("t4_slave",     s_last[0],     32'h1357_9BDF);

    // Reset mid-frame
    clear_mon();
    send(0, 32'hFFFF_0000);
    n = 0;
    while (n_rise[0] < 10 && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) check("t5_rise_timeout", 32'd0, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_ssel", 32'(ssel[0]), 32'd1);
    check("t5_sck",  32'(sck[0]),  32'd0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("t5_no_rx_valid", 32'(n_rxv[0]), 32'd0);
    check("t5_no_slave",    32'(n_rdy[0]), 32'd0);
    clear_mon();
    send(0, 32'h0000_0001);
    wait_idle(0);
    check("t5_next_word", s_last[0],     32'h0000_0001);
    check("t5_next_rdy",  32'(n_rdy[0]), 32'd1);

    // MISO tied high / low
    miso_mode[0] = 2'd1;
    send(0, 32'h0000_0000);
    wait_idle(0);
    check("t6_miso_one", 32'(rx_data[0]), 32'h0000_FFFF);
    miso_mode[0] = 2'd2;
    send(0, 32'hFFFF_FFFF);
    wait_idle(0);
    check("t6_miso_zero", 32'(rx_data[0]), 32'h0000_0000);
    miso_mode[0] = 2'd0;

    // CLK_DIV=5 loopback
    clear_mon();
    send(1, 32'h8040_0ABC);
    wait_idle(1);
    check("t6_div5_word",  s_last[1],       32'h8040_0ABC);
    check("t6_div5_rdy",   32'(n_rdy[1]),   32'd1);
    check("t6_div5_rx",    32'(rx_data[1]), 32'h0000_BEEF);
    check("t6_div5_rxv",   32'(n_rxv[1]),   32'd1);
    check("t6_div5_ssel",  32'(n_low[1]),   32'd328);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
